// File: rtl/fpu_pkg.sv
// Shared single-precision field widths, constants and operand layout for the FPU blocks.
package fpu_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 23;
  localparam int unsigned BIAS     = 127;
  localparam int unsigned QNAN_BIT = 22;
  localparam logic [31:0] POS_INF  = 32'h7F800000;

  // Reciprocal datapath: 26 quotient bits, 25-bit significand (hidden + 23 + guard)
  localparam int unsigned Q_W    = 26;
  localparam int unsigned SIG_W  = 25;
  localparam int unsigned WIDE_W = SIG_W + Q_W;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned XE_W   = 10;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/fp_lzc24.sv
// 24-bit leading-zero counter; all-zero input reports 24.
module fp_lzc24 (
  input  logic [23:0] a,
  output logic [4:0]  lz_c
);

  // Scan upward so the highest set bit wins
  always_comb begin
    lz_c = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (a[i]) lz_c = 5'(23 - i);
    end
  end

endmodule

// File: rtl/finv_core.sv
// Iterative IEEE-754 single reciprocal y = 1/x, one quotient bit per cycle, RNE rounding.
// Fixed 28-cycle latency from accepted start to done, specials included.
module finv_core
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] x,
  output logic        busy,
  output logic        done,
  output logic [31:0] y,
  output logic        ovf,
  output logic        udf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] DIV   = 2'd2;
  localparam logic [1:0] ROUND = 2'd3;

  logic [1:0]             state, state_nxt;
  fp32_t                  xin, xin_nxt;
  logic                   spec, spec_nxt;
  logic [31:0]            spec_y, spec_y_nxt;
  logic [23:0]            dvs, dvs_nxt;
  logic [Q_W-1:0]         rem, rem_nxt;
  logic [Q_W-1:0]         quo, quo_nxt;
  logic signed [XE_W-1:0] nexp, nexp_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   busy_nxt, done_nxt, ovf_nxt, udf_nxt;
  logic [31:0]            y_nxt;

  logic [4:0]             lz;
  logic [Q_W-1:0]         diff;

  logic [SIG_W-1:0]       sig;
  logic signed [XE_W-1:0] rexp, eb, shv;
  logic [4:0]             sh;
  logic [WIDE_W-1:0]      wide;
  logic [7:0]             ebf;
  logic                   sticky, rup;
  logic [30:0]            mag;
  logic [31:0]            rnd_y;
  logic                   rnd_ovf, rnd_udf;

  // Trailing 1 keeps the count equal to the leading zeros of the 23-bit mantissa
  fp_lzc24 u_lzc (
    .a    ({xin.man, 1'b1}),
    .lz_c (lz)
  );

  assign diff = rem - Q_W'(dvs);

  // Rounding stage: pick the significand window, denormalize if needed, then RNE
  always_comb begin
    if (quo[Q_W-1]) begin
      sig  = quo[Q_W-1:1];
      rexp = nexp;
    end else begin
      sig  = quo[Q_W-2:0];
      rexp = nexp - 10'sd1;
    end
    eb  = XE_W'(BIAS) + rexp;
    shv = 10'sd1 - eb;
    sh  = 5'd0;
    ebf = eb[7:0] - 8'd1;
    if (eb <= 10'sd0) begin
      sh  = (shv > 10'sd26) ? 5'd26 : 5'(shv);
      ebf = 8'd0;
    end
    wide   = {sig, Q_W'(0)} >> sh;
    sticky = (|rem) | (|wide[Q_W-1:0]);
    rup    = wide[Q_W] & (sticky | wide[Q_W+1]);
    // Hidden bit adds back onto exp-1; a subnormal carry lands in exp 1
    mag    = {ebf, 23'd0} + 31'(wide[WIDE_W-1:Q_W+1]) + 31'(rup);

    rnd_y   = {xin.sign, mag};
    rnd_ovf = 1'b0;
    rnd_udf = 1'b0;
    if (spec) begin
      rnd_y = spec_y;
    end else if ((eb >= 10'sd255) || (mag[30:23] == 8'hFF)) begin
      rnd_y   = {xin.sign, POS_INF[30:0]};
      rnd_ovf = 1'b1;
    end else begin
      rnd_udf = (mag[30:23] == 8'd0);
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt  = state;
    xin_nxt    = xin;
    spec_nxt   = spec;
    spec_y_nxt = spec_y;
    dvs_nxt    = dvs;
    rem_nxt    = rem;
    quo_nxt    = quo;
    nexp_nxt   = nexp;
    cnt_nxt    = cnt;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    y_nxt      = y;
    ovf_nxt    = ovf;
    udf_nxt    = udf;

    case (state)
      IDLE: begin
        if (start) begin
          xin_nxt   = x;
          busy_nxt  = 1'b1;
          state_nxt = NORM;
        end
      end
      NORM: begin
        spec_nxt   = 1'b0;
        spec_y_nxt = {xin.sign, 31'd0};
        dvs_nxt    = {1'b1, xin.man};
        nexp_nxt   = XE_W'(BIAS) - XE_W'(xin.exp);
        if (xin.exp == 8'hFF) begin
          spec_nxt = 1'b1;
          if (xin.man != '0) spec_y_nxt = 32'(xin) | (32'd1 << QNAN_BIT);
        end else if (xin.exp == 8'd0) begin
          if (xin.man == '0) begin
            spec_nxt   = 1'b1;
            spec_y_nxt = POS_INF | {xin.sign, 31'd0};
          end else begin
            dvs_nxt  = 24'({1'b0, xin.man} << (lz + 5'd1));
            nexp_nxt = XE_W'(BIAS) + XE_W'(lz);
          end
        end
        rem_nxt   = Q_W'(32'd1 << MAN_W);
        quo_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = DIV;
      end
      DIV: begin
        if (rem >= Q_W'(dvs)) begin
          rem_nxt = {diff[Q_W-2:0], 1'b0};
          quo_nxt = {quo[Q_W-2:0], 1'b1};
        end else begin
          rem_nxt = {rem[Q_W-2:0], 1'b0};
          quo_nxt = {quo[Q_W-2:0], 1'b0};
        end
        cnt_nxt = cnt + 5'd1;
        if (cnt == CNT_W'(Q_W - 1)) state_nxt = ROUND;
      end
      default: begin
        y_nxt     = rnd_y;
        ovf_nxt   = rnd_ovf;
        udf_nxt   = rnd_udf;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      xin    <= '0;
      spec   <= 1'b0;
      spec_y <= '0;
      dvs    <= '0;
      rem    <= '0;
      quo    <= '0;
      nexp   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      y      <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      state  <= state_nxt;
      xin    <= xin_nxt;
      spec   <= spec_nxt;
      spec_y <= spec_y_nxt;
      dvs    <= dvs_nxt;
      rem    <= rem_nxt;
      quo    <= quo_nxt;
      nexp   <= nexp_nxt;
      cnt    <= cnt_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      y      <= y_nxt;
      ovf    <= ovf_nxt;
      udf    <= udf_nxt;
    end
  end

endmodule

// File: tb/tb_finv_core.sv
// Scoreboard bench for finv_core: directed corner cases plus randomized operands
// checked against a real-arithmetic reciprocal with explicit RNE rounding.
module tb_finv_core;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x = '0;
  logic        busy, done, ovf, udf;
  logic [31:0] y;

  typedef struct packed {
    logic [31:0] xin;
    logic [31:0] y;
    logic        ovf;
    logic        udf;
    int          issue;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  finv_core dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .x     (x),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .ovf   (ovf),
    .udf   (udf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decode x to a real, divide, locate the binade, round to 24 bits RNE
  function automatic logic [33:0] ref_inv(input logic [31:0] v);
    logic s;
    int   e_in, man, e, mi, ex;
    real  xv, q, p, sc, fr;
    s    = v[31];
    e_in = int'(v[30:23]);
    man  = int'(v[22:0]);
    if (e_in == 255) begin
      if (man != 0) return {2'b00, v | 32'h00400000};
      return {2'b00, s, 31'h0};
    end
    if (e_in == 0 && man == 0) return {2'b00, s, 31'h7F800000};
    p = 1.0;
    if (e_in == 0) begin
      for (int i = 0; i < 149; i++) p = p / 2.0;
      xv = real'(man) * p;
    end else begin
      ex = e_in - 150;
      if (ex >= 0) for (int i = 0; i < ex; i++) p = p * 2.0;
      else for (int i = 0; i < -ex; i++) p = p / 2.0;
      xv = real'(man + 8388608) * p;
    end
    q = 1.0 / xv;
    p = 1.0;
    e = 0;
    while (q >= 2.0 * p) begin p = p * 2.0; e++; end
    while (q < p) begin p = p / 2.0; e--; end
    while (e < -126) begin p = p * 2.0; e++; end
    sc = (q / p) * 8388608.0;
    mi = $rtoi(sc);
    fr = sc - real'(mi);
    if (fr > 0.5 || (fr == 0.5 && (mi % 2) == 1)) mi++;
    if (mi >= 16777216) begin mi = mi / 2; e++; end
    if (mi < 8388608) return {2'b01, s, 8'd0, 23'(mi)};
    ex = e + 127;
    if (ex >= 255) return {2'b10, s, 8'hFF, 23'd0};
    return {2'b00, s, 8'(ex), 23'(mi - 8388608)};
  endfunction

  // Accept x at the next edge once idle; expected = {ovf, udf, y}
  task automatic issue(input logic [31:0] v, input logic [33:0] ex);
    int w = 0;
    @(negedge clk);
    while (busy && w < 100) begin @(negedge clk); w++; end
    if (busy) begin
      n_err++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, w);
    end
    start = 1'b1;
    x     = v;
    exp_q.push_back('{xin: v, y: ex[31:0], ovf: ex[33], udf: ex[32], issue: cyc + 1});
    @(negedge clk);
    start = 1'b0;
    x     = $urandom;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_start x=%h: got %b, required 1", v, busy);
    end
  endtask

  logic [31:0] dx [14] = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h00000000,
                           32'h80000000, 32'hFF800000, 32'h7F800001, 32'h00000001,
                           32'h00200000, 32'h00400000, 32'h7F7FFFFF, 32'hFF000000,
                           32'h3F800000, 32'h7F800000};
  logic [31:0] dy [14] = '{32'h3F000000, 32'h3EAAAAAB, 32'h3F2AAAAB, 32'h7F800000,
                           32'hFF800000, 32'h80000000, 32'h7FC00001, 32'h7F800000,
                           32'h7F800000, 32'h7F000000, 32'h00200000, 32'h80400000,
                           32'h3F800000, 32'h00000000};
  logic [1:0]  df [14] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                           2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};

  initial begin
    exp_t        e;
    logic [31:0] last_y;
    logic [31:0] v;
    int          w;
    last_y = '0;

    // Monitor: pop and compare on every done; y must hold between dones
    fork
      forever begin
        @(negedge clk);
        if (!rstn) begin
          last_y = '0;
        end else if (done) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done: got y=%h, required no done", y);
          end else begin
            e = exp_q.pop_front();
            if (y !== e.y || ovf !== e.ovf || udf !== e.udf || (cyc - e.issue) != 28) begin
              n_err++;
              $display("FAIL result x=%h: got y=%h ovf=%b udf=%b lat=%0d, required y=%h ovf=%b udf=%b lat=28",
                       e.xin, y, ovf, udf, cyc - e.issue, e.y, e.ovf, e.udf);
            end
          end
          last_y = y;
        end else if (y !== last_y) begin
          n_err++;
          $display("FAIL hold: y=%h changed without done, required %h", y, last_y);
          last_y = y;
        end
      end
    join_none

    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, y, ovf, udf} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b y=%h ovf=%b udf=%b, required all 0",
               busy, done, y, ovf, udf);
    end
    rstn = 1'b1;

    for (int i = 0; i < 14; i++) issue(dx[i], {df[i], dy[i]});

    // start pulsed while busy is ignored; result of the first op is unaffected
    issue(32'h40400000, {2'b00, 32'h3EAAAAAB});
    repeat (4) @(negedge clk);
    start = 1'b1;
    x     = 32'h40000000;
    repeat (3) @(negedge clk);
    start = 1'b0;

    // start held across the done edge: accepted one edge later
    issue(32'h3FC00000, {2'b00, 32'h3F2AAAAB});
    repeat (27) @(negedge clk);
    start = 1'b1;
    x     = 32'h40000000;
    repeat (2) @(negedge clk);
    exp_q.push_back('{xin: 32'h40000000, y: 32'h3F000000, ovf: 1'b0, udf: 1'b0, issue: cyc});
    start = 1'b0;

    // Reset mid-operation aborts; no done afterwards
    issue(32'h40000000, {2'b00, 32'h3F000000});
    repeat (9) @(negedge clk);
    rstn = 1'b0;
    #1;
    exp_q.delete();
    n_vec++;
    if ({busy, done, y, ovf, udf} !== 35'd0) begin
      n_err++;
      $display("FAIL mid_reset: got busy=%b done=%b y=%h ovf=%b udf=%b, required all 0",
               busy, done, y, ovf, udf);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 1200; i++) begin
      v = $urandom;
      case ($urandom_range(0, 4))
        0: v[30:23] = 8'($urandom_range(0, 2));
        1: v[30:23] = 8'($urandom_range(250, 255));
        2: v[22:0]  = 23'd0;
        default: ;
      endcase
      issue(v, ref_inv(v));
    end

    w = 0;
    while (exp_q.size() != 0 && w < 200) begin @(negedge clk); w++; end
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
